// File: rtl/background_subtraction_mask.sv
// Background subtraction mask: |image - background| thresholded into a
// 1-bit foreground mask through a fixed 3-stage pipeline (no backpressure).
// Ports: clk, rst_n (async, active low); ce/in_sof/in_image/in_background/
//   threshold in; out_ce/out_sof/out_diff/out_mask out, 3 cycles after ce;
//   fg_count/fg_count_vld: per-frame foreground count.
// Macro BGSUB_FG_COUNT_EN enables the per-frame foreground counter;
//   when undefined, fg_count and fg_count_vld are tied to 0.
module background_subtraction_mask #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_image,
    input  logic [PIX_W-1:0] in_background,
    input  logic [PIX_W-1:0] threshold,
    output logic             out_ce,
    output logic             out_sof,
    output logic [PIX_W-1:0] out_diff,
    output logic             out_mask,
    output logic [CNT_W-1:0] fg_count,
    output logic             fg_count_vld
);

    logic [PIX_W-1:0] thr_act_q, thr_act_d;

    logic             s1_vld_q,  s1_sof_q;
    logic [PIX_W:0]   s1_diff_q, s1_diff_d;
    logic [PIX_W-1:0] s1_thr_q;

    logic             s2_vld_q,  s2_sof_q;
    logic [PIX_W-1:0] s2_abs_q,  s2_abs_d;
    logic [PIX_W-1:0] s2_thr_q;

    logic             out_ce_q,   out_sof_q;
    logic [PIX_W-1:0] out_diff_q, out_diff_d;
    logic             out_mask_q, out_mask_d;

    logic             sof_in;
    logic [PIX_W:0]   neg_diff;

    always_comb begin
        sof_in    = ce & in_sof;
        // Each pixel carries the threshold of its own frame down the pipe;
        // the sof pixel already uses the newly sampled value.
        thr_act_d = sof_in ? threshold : thr_act_q;
        s1_diff_d = {1'b0, in_image} - {1'b0, in_background};
        neg_diff  = ~s1_diff_q + 1'b1;
        s2_abs_d  = s1_diff_q[PIX_W] ? neg_diff[PIX_W-1:0]
                                     : s1_diff_q[PIX_W-1:0];
        // Data outputs hold their last valid value across ce gaps.
        out_diff_d = out_diff_q;
        out_mask_d = out_mask_q;
        if (s2_vld_q) begin
            out_diff_d = s2_abs_q;
            out_mask_d = s2_abs_q > s2_thr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_act_q  <= '1;
            s1_vld_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_diff_q  <= '0;
            s1_thr_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_abs_q   <= '0;
            s2_thr_q   <= '0;
            out_ce_q   <= 1'b0;
            out_sof_q  <= 1'b0;
            out_diff_q <= '0;
            out_mask_q <= 1'b0;
        end else begin
            thr_act_q  <= thr_act_d;
            s1_vld_q   <= ce;
            s1_sof_q   <= sof_in;
            s1_diff_q  <= s1_diff_d;
            s1_thr_q   <= thr_act_d;
            s2_vld_q   <= s1_vld_q;
            s2_sof_q   <= s1_sof_q;
            s2_abs_q   <= s2_abs_d;
            s2_thr_q   <= s1_thr_q;
            out_ce_q   <= s2_vld_q;
            out_sof_q  <= s2_sof_q;
            out_diff_q <= out_diff_d;
            out_mask_q <= out_mask_d;
        end
    end

    assign out_ce   = out_ce_q;
    assign out_sof  = out_sof_q;
    assign out_diff = out_diff_q;
    assign out_mask = out_mask_q;

`ifdef BGSUB_FG_COUNT_EN
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] fg_count_q, fg_count_d;
    logic             fg_vld_q, fg_vld_d;

    always_comb begin
        run_d      = run_q;
        fg_count_d = fg_count_q;
        fg_vld_d   = 1'b0;
        if (out_ce_q & out_sof_q) begin
            // Publish the finished frame; the sof pixel opens the new one.
            fg_count_d = run_q;
            fg_vld_d   = 1'b1;
            run_d      = CNT_W'(out_mask_q);
        end else if (out_ce_q & out_mask_q & (run_q != '1)) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= '0;
            fg_count_q <= '0;
            fg_vld_q   <= 1'b0;
        end else begin
            run_q      <= run_d;
            fg_count_q <= fg_count_d;
            fg_vld_q   <= fg_vld_d;
        end
    end

    assign fg_count     = fg_count_q;
    assign fg_count_vld = fg_vld_q;
`else
    assign fg_count     = '0;
    assign fg_count_vld = 1'b0;
`endif

endmodule

// File: tb/tb_background_subtraction_mask.sv
// Self-checking bench for background_subtraction_mask: vector table,
// hand-written corner sequences and randomized stream vs. a reference model.
module tb_background_subtraction_mask;

    localparam int PW = 8;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          in_sof;
    logic [PW-1:0] in_image;
    logic [PW-1:0] in_background;
    logic [PW-1:0] threshold;
    logic          out_ce;
    logic          out_sof;
    logic [PW-1:0] out_diff;
    logic          out_mask;
    logic [CW-1:0] fg_count;
    logic          fg_count_vld;

    background_subtraction_mask #(.PIX_W(PW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .in_sof       (in_sof),
        .in_image     (in_image),
        .in_background(in_background),
        .threshold    (threshold),
        .out_ce       (out_ce),
        .out_sof      (out_sof),
        .out_diff     (out_diff),
        .out_mask     (out_mask),
        .fg_count     (fg_count),
        .fg_count_vld (fg_count_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ce;
        logic       sof;
        int         img;
        int         bg;
        int         thr;
    } pix_t;

    typedef struct {
        string      name;
        logic       sof;
        int         img;
        int         bg;
        int         thr;
        int         ed;
        logic       em;
    } vec_t;

    pix_t   hist[$];
    int     checks   = 0;
    int     failures = 0;
    int     frame_thr;
    logic   exp_ce, exp_sof, exp_mask;
    int     exp_diff;
    longint run_cnt, exp_fgc;
    logic   exp_fgv;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pix_t idle;
        idle = '{ce: 1'b0, sof: 1'b0, img: 0, bg: 0, thr: 0};
        hist.delete();
        hist.push_back(idle);
        hist.push_back(idle);
        frame_thr = 255;
        exp_ce    = 1'b0;
        exp_sof   = 1'b0;
        exp_diff  = 0;
        exp_mask  = 1'b0;
        run_cnt   = 0;
        exp_fgc   = 0;
        exp_fgv   = 1'b0;
    endtask

    // One clock: model consumes the sampled inputs, then all outputs compared.
    task automatic step();
        pix_t p, e;
        int   d;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            p.ce  = ce;
            p.sof = in_sof;
            p.img = int'(in_image);
            p.bg  = int'(in_background);
            if (ce && in_sof) frame_thr = int'(threshold);
            p.thr = frame_thr;
`ifdef BGSUB_FG_COUNT_EN
            exp_fgv = 1'b0;
            if (exp_ce && exp_sof) begin
                exp_fgc = run_cnt;
                exp_fgv = 1'b1;
                run_cnt = exp_mask ? 1 : 0;
            end else if (exp_ce && exp_mask &&
                         run_cnt < (longint'(1) << CW) - 1) begin
                run_cnt++;
            end
`endif
            hist.push_back(p);
            e = hist.pop_front();
            exp_ce  = e.ce;
            exp_sof = e.ce & e.sof;
            if (e.ce) begin
                d = e.img - e.bg;
                if (d < 0) d = -d;
                exp_diff = d;
                exp_mask = d > e.thr;
            end
        end
        chk("out_ce", out_ce, exp_ce);
        chk("out_sof", out_sof, exp_sof);
        chk("out_diff", out_diff, exp_diff);
        chk("out_mask", out_mask, exp_mask);
        chk("fg_count", fg_count, exp_fgc);
        chk("fg_count_vld", fg_count_vld, exp_fgv);
    endtask

    task automatic drive(input logic c, input logic s, input int img,
                         input int bg, input int thr);
        ce            = c;
        in_sof        = s;
        in_image      = PW'(img);
        in_background = PW'(bg);
        threshold     = PW'(thr);
    endtask

    // Single pixel followed by idle cycles; checked at its output slot.
    task automatic apply_iso(input string name, input logic s, input int img,
                             input int bg, input int thr, input int ed,
                             input logic em);
        drive(1'b1, s, img, bg, thr);
        step();
        ce     = 1'b0;
        in_sof = 1'b0;
        step();
        step();
        chk({name, "_ce"}, out_ce, 1'b1);
        chk({name, "_sof"}, out_sof, s);
        chk({name, "_diff"}, out_diff, ed);
        chk({name, "_mask"}, out_mask, em);
    endtask

    vec_t vt[7];
    logic pat[5];
    logic oce[8];
    int   odiff[8];
    int   r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{"t1_fg",      1'b1, 200,  50, 100, 150, 1'b1};
        vt[1] = '{"t2_strict",  1'b1,  50, 200, 150, 150, 1'b0};
        vt[2] = '{"t2_max",     1'b1,   0, 255, 254, 255, 1'b1};
        vt[3] = '{"thr0_zero",  1'b1,  10,  10,   0,   0, 1'b0};
        vt[4] = '{"thr0_one",   1'b1,  11,  10,   0,   1, 1'b1};
        vt[5] = '{"thrff_max",  1'b1, 255,   0, 255, 255, 1'b0};
        vt[6] = '{"thr_ignore", 1'b0, 100,  40,   0,  60, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();

        foreach (vt[i])
            apply_iso(vt[i].name, vt[i].sof, vt[i].img, vt[i].bg,
                      vt[i].thr, vt[i].ed, vt[i].em);

        // Mid-frame threshold change waits for the next sof.
        apply_iso("t3_sof", 1'b1, 80, 30, 100, 50, 1'b0);
        apply_iso("t3_mid0", 1'b0, 30, 80, 10, 50, 1'b0);
        apply_iso("t3_mid1", 1'b0, 80, 30, 10, 50, 1'b0);
        apply_iso("t3_new", 1'b1, 80, 30, 10, 50, 1'b1);

        // ce gaps: valid pattern reappears 3 cycles later, data held.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            if (k < 5) drive(pat[k], 1'b0, 130 + 20 * k, 100, 5);
            else       drive(1'b0, 1'b0, 0, 0, 5);
            if (k == 1 || k == 2) in_image = 8'd250;
            step();
            oce[k]   = out_ce;
            odiff[k] = int'(out_diff);
        end
        for (int k = 0; k < 5; k++) chk("t4_pattern", oce[k + 2], pat[k]);
        chk("t4_tail", oce[7], 1'b0);
        chk("t4_d0", odiff[2], 30);
        chk("t4_hold1", odiff[3], 30);
        chk("t4_hold2", odiff[4], 30);
        chk("t4_d3", odiff[5], 90);
        chk("t4_d4", odiff[6], 110);

        // Async reset with pixels in flight.
        drive(1'b1, 1'b1, 60, 0, 10);
        step();
        drive(1'b1, 1'b0, 70, 0, 10);
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ce", out_ce, 1'b0);
        chk("t5_rst_diff", out_diff, 0);
        step();
        rst_n = 1'b1;
        ce    = 1'b0;
        step();
        chk("t5_after_ce", out_ce, 1'b0);
        chk("t5_after_mask", out_mask, 1'b0);
        apply_iso("t5_pre", 1'b0, 250, 50, 10, 200, 1'b0);
        apply_iso("t5_sof", 1'b1, 60, 10, 10, 50, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            r     = $urandom_range(0, 9);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 255));
            if (r > 6) in_background = in_image ^ PW'($urandom_range(0, 7));
            step();
        end
        rst_n = 1'b1;
        ce    = 1'b0;
        for (int n = 0; n < 4; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
